// File: rtl/cache_def.sv
// cache_def: shared cache request/result types and the cpu_req_buf FSM state
package cache_def;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    // One queued request: the CPU request without its valid flag
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
    } cpu_req_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } cpu_req_buf_state_t;

endpackage

// File: rtl/cpu_req_fifo.sv
// cpu_req_fifo: DEPTH-entry request queue with registered occupancy
module cpu_req_fifo
    import cache_def::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  cpu_req_entry_t           din,
    output cpu_req_entry_t           head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    cpu_req_entry_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr];

    // Storage is write-only on push; its contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(wr_en) - LW'(rd_en);
        end
    end

endmodule

// File: rtl/cpu_req_buf.sv
// cpu_req_buf: queues CPU requests and issues them one at a time to the cache
// controller with a one-cycle idle gap between requests.
// Optional macro CPU_REQ_BUF_STATS_EN adds saturating rd_cnt/wr_cnt outputs.
module cpu_req_buf
    import cache_def::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  cpu_req_type              up_req,
    output logic                     up_full,
    output cpu_result_type           up_res,
    output cpu_req_type              cache_req,
    input  cpu_result_type           cache_res,
    output logic [$clog2(DEPTH):0]   level
`ifdef CPU_REQ_BUF_STATS_EN
    ,
    output logic [15:0]              rd_cnt,
    output logic [15:0]              wr_cnt
`endif
);

    cpu_req_buf_state_t state;
    cpu_req_buf_state_t next_state;
    cpu_req_entry_t     head;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    assign push    = up_req.valid && !full;
    assign pop     = state == BUSY && cache_res.ready;
    assign up_full = full;

    cpu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({up_req.addr, up_req.data, up_req.rw}),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next state and cache-side request; valid drops as soon as reset is seen
    always_comb begin
        next_state = state == IDLE ? (empty ? IDLE : BUSY) :
                     state == BUSY ? (cache_res.ready ? GAP : BUSY) :
                                     (empty ? IDLE : BUSY);
        cache_req  = '0;
        if (state == BUSY && rst) cache_req = {head.addr, head.data, head.rw, 1'b1};
    end

    // Completion result: one-cycle ready pulse, data held between completions
    always_ff @(posedge clk) begin
        if (!rst)     up_res       <= '0;
        else if (pop) up_res       <= {cache_res.data, 1'b1};
        else          up_res.ready <= 1'b0;
    end

`ifdef CPU_REQ_BUF_STATS_EN
    // Completed read/write counters, saturating at all ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (pop) begin
            if (!head.rw && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            if (head.rw && wr_cnt != 16'hFFFF)  wr_cnt <= wr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_req_buf.sv
// tb_cpu_req_buf: directed scenarios plus random traffic against a queue model
module tb_cpu_req_buf;
    import cache_def::*;

    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    cpu_req_type    up_req;
    cpu_result_type cache_res;
    logic           up_full;
    cpu_result_type up_res;
    cpu_req_type    cache_req;
    logic [2:0]     level;
`ifdef CPU_REQ_BUF_STATS_EN
    logic [15:0]    rd_cnt;
    logic [15:0]    wr_cnt;
    int             m_rd = 0;
    int             m_wr = 0;
`endif

    cpu_req_buf #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_req    (up_req),
        .up_full   (up_full),
        .up_res    (up_res),
        .cache_req (cache_req),
        .cache_res (cache_res),
        .level     (level)
`ifdef CPU_REQ_BUF_STATS_EN
        ,
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: the queue in push order, whether its head is being offered, last result
    cpu_req_entry_t q[$];
    bit             m_issue = 1'b0;
    cpu_result_type m_res = '0;
    int             n_cmp = 0;
    int             n_bad = 0;

    logic [4:0]     pat;
    logic [31:0]    got[$];
    logic [31:0]    ax[3];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle, advance the model by the rules, then cross the edge
    task automatic step();
        bit done;
        bit pend;
        bit pushok;
        @(negedge clk);
        chk("level", level, q.size());
        chk("up_full", up_full, q.size() == DEPTH);
        chk("cache_req", cache_req,
            (m_issue && rst) ? {q[0].addr, q[0].data, q[0].rw, 1'b1} : 66'b0);
        chk("up_res", up_res, m_res);
`ifdef CPU_REQ_BUF_STATS_EN
        chk("rd_cnt", rd_cnt, m_rd);
        chk("wr_cnt", wr_cnt, m_wr);
`endif
        if (!rst) begin
            q.delete();
            m_issue = 1'b0;
            m_res   = '0;
`ifdef CPU_REQ_BUF_STATS_EN
            m_rd = 0;
            m_wr = 0;
`endif
        end else begin
            done   = m_issue && cache_res.ready;
            pend   = q.size() > 0;
            pushok = up_req.valid && q.size() < DEPTH;
            m_res.ready = done;
            if (done) m_res.data = cache_res.data;
`ifdef CPU_REQ_BUF_STATS_EN
            if (done && q[0].rw && m_wr < 16'hFFFF) m_wr++;
            if (done && !q[0].rw && m_rd < 16'hFFFF) m_rd++;
`endif
            m_issue = m_issue ? !done : pend;
            if (done) void'(q.pop_front());
            if (pushok) q.push_back({up_req.addr, up_req.data, up_req.rw});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a, input logic rw);
        up_req = '{addr: a, data: $urandom, rw: rw, valid: 1'b1};
        step();
        up_req.valid = 1'b0;
    endtask

    task automatic drain();
        cache_res.ready = 1'b1;
        for (int i = 0; i < 60 && (q.size() > 0 || m_issue); i++) begin
            cache_res.data = $urandom;
            step();
        end
        cache_res.ready = 1'b0;
        step();
        chk("drain_level", level, 0);
        chk("drain_valid", cache_req.valid, 1'b0);
    endtask

    initial begin
        up_req    = '0;
        cache_res = '0;
        step();
        step();
        chk("rst_level", level, 0);
        chk("rst_cache_req", cache_req, 66'b0);
        chk("rst_up_res", up_res, 33'b0);
        rst = 1'b1;
        step();

        // Single read with a five-cycle cache
        push_req(32'h0000_0040, 1'b0);
        step();
        chk("r030_addr", cache_req.addr, 32'h0000_0040);
        for (int i = 0; i < 4; i++) step();
        chk("r030_valid_held", cache_req.valid, 1'b1);
        cache_res = '{data: 32'hDEAD_BEEF, ready: 1'b1};
        step();
        cache_res.ready = 1'b0;
        chk("r030_res_ready", up_res.ready, 1'b1);
        chk("r030_res_data", up_res.data, 32'hDEAD_BEEF);
        chk("r030_gap", cache_req.valid, 1'b0);
        step();
        chk("r030_res_pulse", up_res.ready, 1'b0);
        chk("r030_res_hold", up_res.data, 32'hDEAD_BEEF);
        step();

        // Fill with the cache stalled, then a dropped fifth push
        for (int i = 0; i < 4; i++) push_req(32'h100 + 32'(i * 4), 1'b1);
        chk("r031_level", level, 4);
        chk("r031_full", up_full, 1'b1);
        push_req(32'h200, 1'b1);
        chk("r031_drop", level, 4);
        drain();

        // Three queued requests, cache answers immediately
        for (int i = 0; i < 3; i++) begin
            ax[i] = 32'h1000 + 32'($urandom_range(0, 255)) * 16;
            push_req(ax[i], 1'(i));
        end
        cache_res.ready = 1'b1;
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            pat = {pat[3:0], cache_req.valid};
            if (cache_req.valid) got.push_back(cache_req.addr);
            cache_res.data = $urandom;
            step();
        end
        cache_res.ready = 1'b0;
        chk("r032_pattern", pat, 5'b10101);
        chk("r032_count", got.size(), 3);
        for (int i = 0; i < 3; i++) chk("r032_order", i < got.size() ? got[i] : 32'hx, ax[i]);
        drain();

        // Push and pop on the same edge at level 2
        push_req(32'h2000, 1'b0);
        push_req(32'h2004, 1'b0);
        chk("r033_pre", level, 2);
        cache_res = '{data: 32'h1234_5678, ready: 1'b1};
        push_req(32'h2008, 1'b1);
        cache_res.ready = 1'b0;
        chk("r033_level", level, 2);
        step();
        chk("r033_next", cache_req.addr, 32'h2004);
        drain();

        // Reset in BUSY with three queued
        for (int i = 0; i < 3; i++) push_req(32'h3000 + 32'(i), 1'b0);
        chk("r034_pre", level, 3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("r034_level", level, 0);
        chk("r034_valid", cache_req.valid, 1'b0);
        cache_res = '{data: 32'hBAD0_BAD0, ready: 1'b1};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r034_no_res", up_res.ready, 1'b0);
        end
        cache_res.ready = 1'b0;
        step();

        // Random traffic, occasional reset, stray readies outside BUSY
        for (int i = 0; i < 800; i++) begin
            up_req    = '{addr: $urandom, data: $urandom, rw: 1'($urandom_range(0, 1)),
                          valid: 1'($urandom_range(0, 2) != 0)};
            cache_res = '{data: $urandom, ready: $urandom_range(0, 3) == 0};
            rst       = $urandom_range(0, 99) != 0;
            step();
        end
        rst = 1'b1;
        up_req.valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
